// File: rtl/bus_sram_responder.sv
// bus_sram_responder: word-addressed SRAM target on the request/ready bus.
// It accepts one transaction per request and waits WAIT_STATES extra cycles.
// It then commits the write or returns read data, and holds ready until the
// initiator withdraws the request.
module bus_sram_responder #(
  parameter int unsigned SIZE        = 10,
  parameter logic [31:0] BASE        = 32'h00000000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_error
);

  localparam int unsigned DEPTH = 1 << SIZE;
  localparam logic [7:0]  WS    = 8'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_count;
  logic [7:0]        w_count_nxt;
  logic              r_ready;
  logic              w_ready_nxt;
  logic              r_error;
  logic              w_error_nxt;
  logic [31:0]       r_rdata;
  logic [31:0]       w_rdata_nxt;

  // Transaction captured at accept; later bus changes are ignored.
  logic              r_rw;
  logic              r_hit;
  logic [SIZE-1:0]   r_index;
  logic [31:0]       r_wdata;

  logic [31:0]       r_mem [DEPTH];

  logic              w_hit;
  logic [SIZE-1:0]   w_index;
  logic              w_accept;
  logic              w_complete;
  logic              w_unused;

  // Byte lane bits are irrelevant for a word-only memory.
  assign w_unused   = ^i_address[1:0];

  assign w_hit      = (i_address[31:SIZE+2] == BASE[31:SIZE+2]);
  assign w_index    = i_address[SIZE+1:2];
  assign w_accept   = (r_state == S_IDLE) && i_request;
  assign w_complete = (r_state == S_WAIT) && (r_count == 8'd0);

  assign o_ready    = r_ready;
  assign o_rdata    = r_rdata;
  assign o_error    = r_error;

  // State, wait counter and bus outputs; reset returns everything to idle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ready <= w_ready_nxt;
      r_error <= w_error_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Next state: accept, count down wait states, hold until request drops.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_request)           w_state_nxt = S_WAIT;
      S_WAIT:  if (r_count == 8'd0)     w_state_nxt = S_DONE;
      S_DONE:  if (!i_request)          w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // Next counter and output values; completion fires regardless of request,
  // so a request withdrawn during WAIT still gets a one-cycle ready pulse.
  always_comb begin
    w_count_nxt = r_count;
    w_ready_nxt = r_ready;
    w_error_nxt = r_error;
    w_rdata_nxt = r_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (i_request) w_count_nxt = WS;
      end
      S_WAIT: begin
        if (r_count == 8'd0) begin
          w_ready_nxt = 1'b1;
          w_error_nxt = !r_hit;
          if (!r_rw) w_rdata_nxt = r_hit ? r_mem[r_index] : 32'd0;
        end else begin
          w_count_nxt = r_count - 8'd1;
        end
      end
      S_DONE: begin
        if (!i_request) begin
          w_ready_nxt = 1'b0;
          w_error_nxt = 1'b0;
        end
      end
      default: begin
        w_count_nxt = 8'd0;
      end
    endcase
  end

  // Capture the transaction fields on accept; no reset needed for data.
  always_ff @(posedge i_clock) begin
    if (w_accept) begin
      r_rw    <= i_rw;
      r_hit   <= w_hit;
      r_index <= w_index;
      r_wdata <= i_wdata;
    end
  end

  // Write commits only at the completion edge; reset in WAIT prevents it.
  always_ff @(posedge i_clock) begin
    if (w_complete && r_rw && r_hit) r_mem[r_index] <= r_wdata;
  end

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench for bus_sram_responder. Two instances: a zero-wait
// RAM at address 0 and a three-wait RAM at 0x1000_0000. Both are checked
// against a transaction-level memory model.
module tb_bus_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        sel = 1'b0;

  logic        req0, req1;
  logic        rdy0, rdy1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        rdy, err;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mm    [2][1024];
  bit          known [2][1024];
  logic [31:0] exp_rd [2];
  bit          exp_rd_valid [2];

  always #5 clk = ~clk;

  assign req0  = req & ~sel;
  assign req1  = req & sel;
  assign rdy   = sel ? rdy1 : rdy0;
  assign err   = sel ? err1 : err0;
  assign rdata = sel ? rdata1 : rdata0;

  bus_sram_responder #(.SIZE(10), .BASE(32'h00000000), .WAIT_STATES(0)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_request(req0), .i_rw(rw),
    .i_address(addr), .i_wdata(wdata),
    .o_ready(rdy0), .o_rdata(rdata0), .o_error(err0)
  );

  bus_sram_responder #(.SIZE(10), .BASE(32'h10000000), .WAIT_STATES(3)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_request(req1), .i_rw(rw),
    .i_address(addr), .i_wdata(wdata),
    .o_ready(rdy1), .o_rdata(rdata1), .o_error(err1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input logic s);
    return s ? 32'h10000000 : 32'h00000000;
  endfunction

  function automatic int ws_of(input logic s);
    return s ? 3 : 0;
  endfunction

  function automatic logic [31:0] rand_addr(input logic s);
    logic [31:0] b;
    int r;
    b = base_of(s);
    r = $urandom_range(0, 9);
    if (r == 0)      return $urandom;
    else if (r == 1) return b + 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
    else             return b + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      exp_rd[s] = 32'd0;
      exp_rd_valid[s] = 1'b1;
    end
  endtask

  // One full bus transaction on the selected instance, checked against the model.
  task automatic do_txn(input bit t_rw, input logic [31:0] t_addr, input logic [31:0] t_wd,
                        input int hold, input bit early);
    logic [31:0] b;
    bit          hit;
    int          idx;
    int          n;
    bit          got;
    int          ws;
    b   = base_of(sel);
    ws  = ws_of(sel);
    hit = (t_addr[31:12] == b[31:12]);
    idx = int'(t_addr[11:2]);
    @(negedge clk);
    req = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wd;
    @(posedge clk);
    got = 1'b0;
    n = 0;
    while (!got && n < ws + 10) begin
      @(negedge clk);
      if (early) req = 1'b0;
      addr = $urandom; wdata = $urandom; rw = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
      if (rdy) got = 1'b1;
    end
    check_val("ready_seen", {31'd0, got}, 32'd1);
    check_val("latency", n, ws + 1);
    check_val("error", {31'd0, err}, {31'd0, !hit});
    if (t_rw) begin
      if (exp_rd_valid[sel]) check_val("wr_rdata_hold", rdata, exp_rd[sel]);
      if (hit) begin
        mm[sel][idx] = t_wd;
        known[sel][idx] = 1'b1;
      end
    end else begin
      if (!hit) begin
        exp_rd[sel] = 32'd0;
        exp_rd_valid[sel] = 1'b1;
      end else if (known[sel][idx]) begin
        exp_rd[sel] = mm[sel][idx];
        exp_rd_valid[sel] = 1'b1;
      end else begin
        exp_rd_valid[sel] = 1'b0;
      end
      if (exp_rd_valid[sel]) check_val("rd_data", rdata, exp_rd[sel]);
    end
    if (early) begin
      @(posedge clk);
      #1;
      check_val("pulse_drop", {31'd0, rdy}, 32'd0);
    end else begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        addr = $urandom; wdata = $urandom; rw = 1'($urandom);
        @(posedge clk);
        #1;
        check_val("ready_hold", {31'd0, rdy}, 32'd1);
      end
      @(negedge clk);
      req = 1'b0;
      @(posedge clk);
      #1;
      check_val("ready_release", {31'd0, rdy}, 32'd0);
      check_val("error_release", {31'd0, err}, 32'd0);
    end
  endtask

  initial begin
    bit got;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) known[s][i] = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rdy0", {31'd0, rdy0}, 32'd0);
    check_val("rst_err0", {31'd0, err0}, 32'd0);
    check_val("rst_rdata0", rdata0, 32'd0);
    check_val("rst_rdy1", {31'd0, rdy1}, 32'd0);
    check_val("rst_rdata1", rdata1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait instance: write then read, plus an out-of-range read
    sel = 1'b0;
    do_txn(1'b1, 32'h00000010, 32'hCAFEF00D, 0, 1'b0);
    do_txn(1'b0, 32'h00000010, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'h00001000, 32'h0, 0, 1'b0);

    // Three-wait instance: read with long hold after ready
    sel = 1'b1;
    do_txn(1'b1, 32'h10000024, 32'h12345678, 0, 1'b0);
    do_txn(1'b0, 32'h10000024, 32'h0, 5, 1'b0);

    // Out-of-range write just past the end must not alias index 0
    do_txn(1'b1, 32'h10000000, 32'h00000077, 0, 1'b0);
    do_txn(1'b1, 32'h10001000, 32'hDEADBEEF, 0, 1'b0);
    do_txn(1'b0, 32'h10000000, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'h10001000, 32'h0, 0, 1'b0);

    // Reset during WAIT: pending write must be lost
    do_txn(1'b1, 32'h10000008, 32'h11111111, 0, 1'b0);
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = 32'h10000008; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rstwait_rdy", {31'd0, rdy}, 32'd0);
    check_val("rstwait_rdata", rdata, 32'd0);
    req = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_txn(1'b0, 32'h10000008, 32'h0, 0, 1'b0);

    // Reset during DONE: ready drops at once, committed write survives
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = 32'h10000008; wdata = 32'h22222222;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      got = rdy;
    end
    check_val("rstdone_seen", {31'd0, got}, 32'd1);
    mm[1][2] = 32'h22222222;
    known[1][2] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rstdone_rdy", {31'd0, rdy}, 32'd0);
    check_val("rstdone_err", {31'd0, err}, 32'd0);
    req = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_txn(1'b0, 32'h10000008, 32'h0, 0, 1'b0);

    // Request withdrawn during WAIT: single pulse, write still committed
    do_txn(1'b1, 32'h10000004, 32'h0BADF00D, 0, 1'b1);
    do_txn(1'b0, 32'h10000004, 32'h0, 0, 1'b0);
    sel = 1'b0;
    do_txn(1'b1, 32'h00000004, 32'h600DCAFE, 0, 1'b1);
    do_txn(1'b0, 32'h00000004, 32'h0, 0, 1'b0);

    // Randomized traffic on both instances
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      sel = 1'($urandom);
      do_txn(1'($urandom), rand_addr(sel), $urandom, $urandom_range(0, 2),
             ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
